mult_seq_32: RTL and testbench

MULT_SEQ_32 -- requirements
Module: mult_seq_32

---
 rtl/mult_seq_32.sv | 120 ++++++++++++
 tb/tb_mult_seq_32.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mult_seq_32.sv
// Sequential 32x32 -> 64 shift-add multiplier, signed or unsigned, one
// partial-product add per cycle through an external 32-bit adder.
module mult_seq_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_s,
  input  logic        add_g,
  input  logic        add_p,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mcand_q, mcand_d;
  logic        neg_q, neg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] abs_a, abs_b;
  logic [63:0] prod_neg;
  logic        carry;

  assign add_cin   = 1'b0;
  assign add_a     = (state_q == S_CALC) ? hi_q : 32'd0;
  assign add_b     = (state_q == S_CALC && lo_q[0]) ? mcand_q : 32'd0;
  assign carry     = add_g | (add_p & add_cin);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign abs_a    = (sgn && a[31]) ? (~a + 32'd1) : a;
  assign abs_b    = (sgn && b[31]) ? (~b + 32'd1) : b;
  assign prod_neg = ~{hi_q, lo_q} + 64'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = abs_a;
          lo_d    = abs_b;
          hi_d    = 32'd0;
          neg_d   = sgn & (a[31] ^ b[31]);
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Shift the accumulated sum right one bit; adder carry becomes the new MSB.
        {hi_d, lo_d} = {carry, add_s, lo_q[31:1]};
        cnt_d        = cnt_q + 5'd1;
        busy_d       = 1'b1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (neg_q) {hi_d, lo_d} = prod_neg;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      mcand_q <= 32'd0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_seq_32.sv
// Bench for mult_seq_32: behavioural adder and product model, directed
// corner cases, start re-pulse, mid-operation reset, then random operands.
module tb_mult_seq_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a, b;
  logic [31:0] add_a, add_b;
  logic        add_cin;
  logic [31:0] add_s;
  logic        add_g, add_p;
  logic [31:0] hi, lo;
  logic        busy, done;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  mult_seq_32 dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s),
    .add_g(add_g), .add_p(add_p), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external carry-lookahead adder, modelled at group level
  logic [32:0] gen_sum;
  assign gen_sum = {1'b0, add_a} + {1'b0, add_b};
  assign add_s   = add_a + add_b + {31'd0, add_cin};
  assign add_g   = gen_sum[32];
  assign add_p   = &(add_a ^ add_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // driver: issue one multiply, track busy/done, score the result
  task automatic run_mult(input string tag, input logic s, input logic [31:0] x,
                          input logic [31:0] y, input bit repulse);
    int busy_cnt;
    int done_at;
    int done_cnt;
    logic [63:0] exp;
    logic [63:0] res;
    exp_q.push_back(ref_mul(s, x, y));
    @(negedge clk);
    start = 1'b1; sgn = s; a = x; b = y;
    @(negedge clk);
    // operands change right after acceptance and must not be resampled
    start = 1'b0; sgn = $urandom_range(0, 1); a = $urandom; b = $urandom;
    busy_cnt = 0;
    done_at  = -1;
    for (int j = 0; j < 40 && done_at < 0; j++) begin
      if (j > 0) @(negedge clk);
      if (repulse && j == 5) begin start = 1'b1; sgn = ~s; a = $urandom; b = $urandom; end
      if (repulse && j == 6) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_at = j;
      if (j == 32) check({tag, "_add_zero_fix"}, {add_a, add_b}, 64'd0);
    end
    check({tag, "_done_lat"}, 64'(done_at), 64'd33);
    check({tag, "_busy_cyc"}, 64'(busy_cnt), 64'd33);
    exp = exp_q.pop_front();
    res = {hi, lo};
    check({tag, "_product"}, res, exp);
    done_cnt = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check({tag, "_extra_done"}, 64'(done_cnt), 64'd0);
    check({tag, "_hold"}, {hi, lo}, exp);
    check({tag, "_idle"}, {62'd0, busy, add_a == 32'd0 && add_b == 32'd0}, 64'd1);
  endtask

  // reset asserted at CALC iteration 10 must abort silently
  task automatic run_abort(input logic [31:0] x, input logic [31:0] y);
    int done_cnt;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_state", {hi, lo}, 64'd0);
    check("abort_flags", {60'd0, state_dbg, busy, done}, 64'd0);
    rst = 1'b0;
    start = 1'b0;
    done_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
  endtask

  initial begin
    logic s;
    logic [31:0] x, y;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = 32'd0; b = 32'd0;
    // rst wins over start
    repeat (2) @(negedge clk);
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", {60'd0, state_dbg, busy, done}, 64'd0);
    check("reset_adder", {31'd0, add_cin, add_a}, 64'd0);
    start = 1'b0;
    rst = 1'b0;

    run_mult("u3x5", 1'b0, 32'd3, 32'd5, 1'b0);
    check("u3x5_exact", {hi, lo}, 64'h0000_0000_0000_000F);
    run_mult("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("umax_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_mult("sm2x3", 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("sm2x3_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_mult("smin", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("smin_exact", {hi, lo}, 64'h4000_0000_0000_0000);
    run_mult("repulse", 1'b0, 32'd1234, 32'd5678, 1'b1);
    check("repulse_exact", {hi, lo}, 64'd7006652);

    run_abort(32'hDEAD_BEEF, 32'h1234_5678);
    run_mult("post_rst", 1'b0, 32'd7, 32'd6, 1'b0);
    check("post_rst_lo", {32'd0, lo}, 64'd42);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      x = pick_operand();
      y = pick_operand();
      run_mult($sformatf("rnd%0d", i), s, x, y, 1'b0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
